dma_ctrl: RTL and testbench

- Sequences outbound DMA transfers from data memory onto the CPU's external DMA port (memDataOut / memAddr / en / nextTransaction).
- Shares the single data-memory read port with the CPU memory stage. The CPU always has priority; the DMA engine fills idle cycles only.
- Raises a sticky completion interrupt that feeds the Interrupt/ack logic in cpu_top.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_ctrl_if.sv | 51 +++++
 rtl/dma_ctrl.sv | 98 +++++++++
 tb/tb_dma_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the outbound DMA controller.
//   dma_state_t : controller FSM states
//   WORD_BYTES  : byte stride between consecutive 32-bit source words
package dma_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    FIN  = 3'd4
  } dma_state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/dma_ctrl_if.sv
// Signal bundle between dma_ctrl and its surroundings (CPU, data memory,
// outbound DMA port, interrupt logic).
//   slave  : the view used by dma_ctrl
//   master : the view used by the system / testbench driving dma_ctrl
// Groups:
//   control   : start, cfg_src, cfg_len, abort, busy, done
//   memory    : cpu_mem_req, dma_mem_rd, dma_mem_addr, mem_rdata
//   outbound  : en, memDataOut, memAddr, nextTransaction
//   interrupt : irq, irq_ack
interface dma_ctrl_if #(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DATA_W = 32
) ();

  logic              start;
  logic [DATA_W-1:0] cfg_src;
  logic [LEN_W-1:0]  cfg_len;
  logic              abort;

  logic              cpu_mem_req;
  logic              dma_mem_rd;
  logic [DATA_W-1:0] dma_mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  logic              en;
  logic [DATA_W-1:0] memDataOut;
  logic [DATA_W-1:0] memAddr;
  logic              nextTransaction;

  logic              busy;
  logic              done;
  logic              irq;
  logic              irq_ack;

  modport slave (
    input  start, cfg_src, cfg_len, abort,
    input  cpu_mem_req, mem_rdata, nextTransaction, irq_ack,
    output dma_mem_rd, dma_mem_addr,
    output en, memDataOut, memAddr,
    output busy, done, irq
  );

  modport master (
    output start, cfg_src, cfg_len, abort,
    output cpu_mem_req, mem_rdata, nextTransaction, irq_ack,
    input  dma_mem_rd, dma_mem_addr,
    input  en, memDataOut, memAddr,
    input  busy, done, irq
  );

endinterface

// File: rtl/dma_ctrl.sv
// Outbound DMA sequencer. Reads cfg_len words starting at cfg_src from the
// shared data-memory read port (CPU has priority) and presents each word on
// the outbound port (en / memDataOut / memAddr) until nextTransaction accepts
// it. Completion gives a one-cycle done pulse and a sticky irq.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dma_ctrl_if.slave, all control/memory/outbound/irq signals
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DATA_W = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  dma_ctrl_if.slave  bus
);

  dma_state_t        state;
  logic [DATA_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] maddr_q;
  logic              irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      data_q  <= '0;
      maddr_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      // Setting in FIN beats a coincident acknowledge; an aborted FIN sets nothing.
      if (state == FIN && !bus.abort)
        irq_q <= 1'b1;
      else if (bus.irq_ack)
        irq_q <= 1'b0;

      // abort overrides every transition, including start in IDLE and an
      // accept in SEND; an in-flight read is simply never captured.
      if (bus.abort) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              if (bus.cfg_len != '0) begin
                addr  <= bus.cfg_src & ~DATA_W'(WORD_BYTES - 1);
                cnt   <= bus.cfg_len;
                state <= READ;
              end else begin
                state <= FIN;
              end
            end
          end
          READ: begin
            if (!bus.cpu_mem_req)
              state <= WAIT;
          end
          WAIT: begin
            data_q  <= bus.mem_rdata;
            maddr_q <= addr;
            state   <= SEND;
          end
          SEND: begin
            if (bus.nextTransaction) begin
              cnt   <= cnt - LEN_W'(1);
              addr  <= addr + DATA_W'(WORD_BYTES);
              state <= (cnt == LEN_W'(1)) ? FIN : READ;
            end
          end
          FIN: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Strobes decode the state register; the read and valid strobes are also
  // gated by the live cpu_mem_req / abort inputs so they drop in the same cycle.
  always_comb begin
    bus.dma_mem_rd   = (state == READ) && !bus.cpu_mem_req && !bus.abort;
    bus.dma_mem_addr = addr;
    bus.en           = (state == SEND) && !bus.abort;
    bus.memDataOut   = data_q;
    bus.memAddr      = maddr_q;
    bus.busy         = (state != IDLE);
    bus.done         = (state == FIN) && !bus.abort;
    bus.irq          = irq_q;
  end

endmodule

// File: tb/tb_dma_ctrl.sv
module tb_dma_ctrl;

  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DATA_W = 32;

  logic clk;
  logic rst_n;

  dma_ctrl_if #(.LEN_W(LEN_W), .DATA_W(DATA_W)) bus ();

  dma_ctrl #(.LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int words = 0;
  int w0;
  logic [63:0] q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Data memory: one-cycle read latency, junk when not being read.
  always @(posedge clk)
    bus.mem_rdata <= bus.dma_mem_rd ? mem_val(bus.dma_mem_addr) : 32'hDEAD_BEEF;

  task automatic push_xfer(input logic [31:0] src, input int len);
    logic [31:0] a;
    a = src & 32'hFFFF_FFFC;
    for (int i = 0; i < len; i++) begin
      q.push_back({a, mem_val(a)});
      a = a + 32'd4;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted outbound word is compared with the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.en && bus.nextTransaction) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $error("FAIL sb_unexpected: got %h/%h expected none", bus.memAddr, bus.memDataOut);
      end else begin
        logic [63:0] e;
        e = q.pop_front();
        assert ({bus.memAddr, bus.memDataOut} === e)
          else begin
            bad++;
            $error("FAIL sb_word: got %h/%h expected %h/%h",
                   bus.memAddr, bus.memDataOut, e[63:32], e[31:0]);
          end
      end
      words++;
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.start = 0; bus.cfg_src = '0; bus.cfg_len = '0; bus.abort = 0;
    bus.cpu_mem_req = 0; bus.nextTransaction = 0; bus.irq_ack = 0;
    #12;
    chk("rst_rd", bus.dma_mem_rd, 0);
    chk("rst_en", bus.en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_dout", bus.memDataOut, 0);
    chk("rst_maddr", bus.memAddr, 0);
    chk("rst_raddr", bus.dma_mem_addr, 0);
    rst_n = 1'b1;

    // Basic: 3 words, consumer always ready.
    bus.nextTransaction = 1;
    cyc(); bus.cfg_src = 32'h100; bus.cfg_len = 3; bus.start = 1; push_xfer(32'h100, 3);
    w0 = words;
    for (int c = 1; c <= 11; c++) begin
      cyc(); bus.start = 0; #1;
      chk("basic_rd", bus.dma_mem_rd, (c <= 9) && (c % 3 == 1));
      chk("basic_en", bus.en, (c <= 9) && (c % 3 == 0));
      chk("basic_done", bus.done, c == 10);
      if (c == 4) chk("basic_raddr", bus.dma_mem_addr, 32'h104);
    end
    chk("basic_irq", bus.irq, 1);
    chk("basic_words", words - w0, 3);
    cyc(); bus.irq_ack = 1; cyc(); bus.irq_ack = 0; #1;
    chk("ack_irq", bus.irq, 0);

    // CPU contention, unaligned source, irq_ack coincident with FIN.
    cyc(); bus.cfg_src = 32'h203; bus.cfg_len = 1; bus.start = 1; push_xfer(32'h203, 1);
    for (int c = 1; c <= 10; c++) begin
      cyc(); bus.start = 0; bus.cpu_mem_req = (c <= 5); bus.irq_ack = (c == 9); #1;
      chk("cont_rd", bus.dma_mem_rd, c == 6);
      chk("cont_en", bus.en, c == 8);
      chk("cont_done", bus.done, c == 9);
      if (c == 6) chk("cont_raddr", bus.dma_mem_addr, 32'h200);
    end
    bus.irq_ack = 0;
    chk("cont_irq_setwins", bus.irq, 1);
    cyc(); bus.irq_ack = 1; cyc(); bus.irq_ack = 0; #1;
    chk("ack_irq2", bus.irq, 0);

    // Back-pressure for 10 cycles, plus an ignored start mid-transfer.
    bus.nextTransaction = 0;
    cyc(); bus.cfg_src = 32'h300; bus.cfg_len = 2; bus.start = 1; push_xfer(32'h300, 2);
    w0 = words;
    for (int c = 1; c <= 18; c++) begin
      cyc(); bus.start = (c == 5); bus.cfg_len = 5;
      bus.nextTransaction = (c == 13) || (c == 16); #1;
      chk("bp_rd", bus.dma_mem_rd, (c == 1) || (c == 14));
      chk("bp_en", bus.en, (c >= 3 && c <= 13) || (c == 16));
      chk("bp_done", bus.done, c == 17);
      if (c >= 3 && c <= 13) begin
        chk("bp_maddr", bus.memAddr, 32'h300);
        chk("bp_dout", bus.memDataOut, mem_val(32'h300));
        chk("bp_raddr", bus.dma_mem_addr, 32'h300);
      end
    end
    chk("bp_words", words - w0, 2);
    chk("bp_irq", bus.irq, 1);
    cyc(); bus.irq_ack = 1; cyc(); bus.irq_ack = 0;

    // Zero length.
    cyc(); bus.cfg_len = 0; bus.start = 1;
    for (int c = 1; c <= 3; c++) begin
      cyc(); bus.start = 0; #1;
      chk("zero_done", bus.done, c == 1);
      chk("zero_busy", bus.busy, c == 1);
      chk("zero_rd", bus.dma_mem_rd, 0);
      chk("zero_en", bus.en, 0);
    end
    chk("zero_irq", bus.irq, 1);
    cyc(); bus.irq_ack = 1; cyc(); bus.irq_ack = 0;

    // start and abort together in IDLE.
    cyc(); bus.cfg_len = 1; bus.start = 1; bus.abort = 1;
    cyc(); bus.start = 0; bus.abort = 0; #1;
    chk("sa_busy", bus.busy, 0);
    chk("sa_rd", bus.dma_mem_rd, 0);

    // Abort on the second word's SEND together with nextTransaction.
    bus.nextTransaction = 1;
    cyc(); bus.cfg_src = 32'h400; bus.cfg_len = 3; bus.start = 1; push_xfer(32'h400, 3);
    w0 = words;
    for (int c = 1; c <= 8; c++) begin
      cyc(); bus.start = 0; bus.abort = (c == 6); #1;
      chk("ab_en", bus.en, c == 3);
      chk("ab_done", bus.done, 0);
      if (c >= 7) chk("ab_busy", bus.busy, 0);
    end
    bus.abort = 0;
    chk("ab_words", words - w0, 1);
    chk("ab_irq", bus.irq, 0);
    q.delete();

    // Address wrap.
    cyc(); bus.cfg_src = 32'hFFFF_FFFC; bus.cfg_len = 2; bus.start = 1;
    push_xfer(32'hFFFF_FFFC, 2);
    for (int c = 1; c <= 8; c++) begin
      cyc(); bus.start = 0; #1;
      chk("wrap_en", bus.en, (c == 3) || (c == 6));
      chk("wrap_done", bus.done, c == 7);
      if (c == 3) chk("wrap_maddr0", bus.memAddr, 32'hFFFF_FFFC);
      if (c == 6) chk("wrap_maddr1", bus.memAddr, 32'h0000_0000);
    end
    chk("wrap_irq", bus.irq, 1);
    chk("sb_drained", q.size(), 0);

    // Asynchronous reset in the middle of SEND (irq still set from above).
    bus.nextTransaction = 0;
    cyc(); bus.cfg_src = 32'h500; bus.cfg_len = 1; bus.start = 1; push_xfer(32'h500, 1);
    for (int c = 1; c <= 3; c++) begin
      cyc(); bus.start = 0;
    end
    #1;
    chk("ar_en_before", bus.en, 1);
    #2; rst_n = 1'b0; #1;
    chk("ar_en", bus.en, 0);
    chk("ar_busy", bus.busy, 0);
    chk("ar_irq", bus.irq, 0);
    chk("ar_rd", bus.dma_mem_rd, 0);
    chk("ar_done", bus.done, 0);
    chk("ar_maddr", bus.memAddr, 0);
    chk("ar_dout", bus.memDataOut, 0);
    chk("ar_raddr", bus.dma_mem_addr, 0);
    q.delete();
    cyc(); rst_n = 1'b1;
    cyc(); cyc(); #1;
    chk("ar_idle", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
